// File: rtl/sample_pkg.sv
// Shared types and defaults for the sample-count producer.
package sample_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      PULSE,
      WAIT,
      DONE
   } sender_state_t;

   localparam int DEFAULT_BATCH = 1000;
   localparam int SAMPLE_W      = 16;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover; rollover_flag is high while count_out == rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] r_count;
   logic [NUM_CNT_BITS-1:0] w_count_nxt;
   logic                    r_flag;
   logic                    w_flag_nxt;

   always_comb begin
      w_count_nxt = r_count;
      if (clear)
         w_count_nxt = '0;
      else if (count_enable)
         w_count_nxt = (r_count == rollover_val) ? NUM_CNT_BITS'(1) : r_count + 1'b1;
      w_flag_nxt = !clear && (w_count_nxt == rollover_val);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
         r_flag  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_flag  <= w_flag_nxt;
      end
   end

   assign count_out     = r_count;
   assign rollover_flag = r_flag;

endmodule

// File: rtl/sample_sender.sv
// Pulls samples from a valid/ready source and hands them to the filter one at a time,
// pulsing cnt_up per delivery and batch_done after BATCH_SIZE deliveries.
module sample_sender
   import sample_pkg::*;
#(
   parameter int DATA_W     = SAMPLE_W,
   parameter int BATCH_SIZE = DEFAULT_BATCH,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              start,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              modwait,
   output logic [DATA_W-1:0] out_data,
   output logic              data_ready,
   output logic              cnt_up,
   output logic              busy,
   output logic              batch_done
);

   localparam logic [CNT_W-1:0] LP_BATCH = CNT_W'(BATCH_SIZE);

   sender_state_t     r_state;
   sender_state_t     w_next;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  w_count;
   logic              w_last;
   logic              w_cnt_clr;
   logic              w_cnt_en;

   // Delivered-sample count; reaching LP_BATCH is "remaining == 0".
   assign w_cnt_clr = clear || ((r_state == IDLE) && start);
   assign w_cnt_en  = (r_state == PULSE) && (w_count != LP_BATCH);

   flex_counter #(
      .NUM_CNT_BITS (CNT_W)
   ) u_remaining (
      .clk           (clk),
      .n_rst         (n_reset),
      .clear         (w_cnt_clr),
      .count_enable  (w_cnt_en),
      .rollover_val  (LP_BATCH),
      .count_out     (w_count),
      .rollover_flag (w_last)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Sample register only moves on an accept; a coincident clear keeps the old value.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         r_data <= '0;
      else if ((r_state == FETCH) && in_valid && !clear)
         r_data <= in_data;
   end

   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start)    w_next = FETCH;
            FETCH:   if (in_valid) w_next = ISSUE;
            ISSUE:   if (!modwait) w_next = PULSE;
            PULSE:                 w_next = WAIT;
            WAIT:    if (!modwait) w_next = w_last ? DONE : FETCH;
            DONE:                  w_next = IDLE;
            default:               w_next = IDLE;
         endcase
      end
   end

   assign in_ready   = (r_state == FETCH);
   assign data_ready = (r_state == PULSE);
   assign cnt_up     = (r_state == PULSE);
   assign busy       = (r_state != IDLE);
   assign batch_done = (r_state == DONE);
   assign out_data   = r_data;

endmodule

// File: tb/tb_sample_sender.sv
// Randomized bench for sample_sender: a 4-sample instance for directed scenarios
// and a default 1000-sample instance for a long random-stall batch.
module tb_sample_sender;

   localparam int DW = 16;

   logic clk = 1'b0;
   logic n_reset;
   always #5 clk = ~clk;

   logic          start[2], clear[2], in_valid[2], modwait[2];
   logic [DW-1:0] in_data[2];
   logic          in_ready[2], data_ready[2], cnt_up[2], busy[2], batch_done[2];
   logic [DW-1:0] out_data[2];

   sample_sender #(.DATA_W(16), .BATCH_SIZE(4), .CNT_W(10)) u_b4 (
      .clk(clk), .n_reset(n_reset), .start(start[0]), .clear(clear[0]),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
      .modwait(modwait[0]), .out_data(out_data[0]), .data_ready(data_ready[0]),
      .cnt_up(cnt_up[0]), .busy(busy[0]), .batch_done(batch_done[0]));

   sample_sender u_b1k (
      .clk(clk), .n_reset(n_reset), .start(start[1]), .clear(clear[1]),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
      .modwait(modwait[1]), .out_data(out_data[1]), .data_ready(data_ready[1]),
      .cnt_up(cnt_up[1]), .busy(busy[1]), .batch_done(batch_done[1]));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int bsz[2] = '{4, 1000};

   // Upstream source: a table of samples, advanced by the model's own accept decision.
   logic [DW-1:0] src[2][64];
   logic [5:0]    acc[2];
   assign in_data[0] = src[0][acc[0]];
   assign in_data[1] = src[1][acc[1]];

   task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, k, $time, a, e);
      end
   endtask

   // Behavioural model: a batch is a sequence of deliveries; each delivery is
   // "get a sample, wait for the filter to be free, strobe, let the filter settle".
   bit            m_act[2], m_await[2], m_have[2], m_strobe[2], m_settle[2], m_fin[2];
   int            m_n[2];
   logic [DW-1:0] m_held[2];

   always @(posedge clk or negedge n_reset) begin
      for (int k = 0; k < 2; k++) begin
         if (!n_reset) begin
            {m_act[k], m_await[k], m_have[k], m_strobe[k], m_settle[k], m_fin[k]} = '0;
            m_n[k] = 0; m_held[k] = '0; acc[k] <= '0;
         end else if (clear[k]) begin
            {m_act[k], m_await[k], m_have[k], m_strobe[k], m_settle[k], m_fin[k]} = '0;
            m_n[k] = 0;
         end else if (m_fin[k]) begin
            m_fin[k] = 0; m_act[k] = 0;
         end else if (!m_act[k]) begin
            if (start[k]) begin m_act[k] = 1; m_await[k] = 1; m_n[k] = 0; end
         end else if (m_await[k]) begin
            if (in_valid[k]) begin
               m_held[k] = in_data[k]; acc[k] <= acc[k] + 1'b1;
               m_await[k] = 0; m_have[k] = 1;
            end
         end else if (m_have[k]) begin
            if (!modwait[k]) begin m_have[k] = 0; m_strobe[k] = 1; end
         end else if (m_strobe[k]) begin
            m_strobe[k] = 0; m_n[k]++; m_settle[k] = 1;
         end else if (m_settle[k]) begin
            if (!modwait[k]) begin
               m_settle[k] = 0;
               if (m_n[k] == bsz[k]) m_fin[k] = 1; else m_await[k] = 1;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Every-cycle comparison against the model, plus event logs for literal checks.
   int            plog_c[2][$];
   logic [DW-1:0] plog_d[2][$];
   int            bd_cnt[2] = '{0, 0};
   int            bd_cyc[2] = '{0, 0};

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk("in_ready",   k, 32'(in_ready[k]),   32'(m_await[k]));
         chk("data_ready", k, 32'(data_ready[k]), 32'(m_strobe[k]));
         chk("cnt_up",     k, 32'(cnt_up[k]),     32'(m_strobe[k]));
         chk("busy",       k, 32'(busy[k]),       32'(m_act[k]));
         chk("batch_done", k, 32'(batch_done[k]), 32'(m_fin[k]));
         chk("out_data",   k, 32'(out_data[k]),   32'(m_held[k]));
         if (cnt_up[k] === 1'b1) begin plog_c[k].push_back(cyc); plog_d[k].push_back(out_data[k]); end
         if (batch_done[k] === 1'b1) begin bd_cnt[k]++; bd_cyc[k] = cyc; end
      end
   end

   task automatic pulse_start(input int k);
      @(posedge clk); #1 start[k] = 1'b1;
      @(posedge clk); #1 start[k] = 1'b0;
   endtask

   task automatic wait_bd(input int k, input int lim, input string nm);
      int b0 = bd_cnt[k];
      int c  = 0;
      while (bd_cnt[k] == b0 && c < lim) begin @(posedge clk); c++; end
      chk(nm, k, 32'(bd_cnt[k] - b0), 32'd1);
      #1;
   endtask

   logic [DW-1:0] exp4[4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

   initial begin
      int b, c;
      logic [DW-1:0] d0;
      for (int k = 0; k < 2; k++) begin
         start[k] = 0; clear[k] = 0; in_valid[k] = 0; modwait[k] = 0;
         for (int i = 0; i < 64; i++) src[k][i] = DW'($urandom);
      end
      for (int i = 0; i < 4; i++) src[0][i] = exp4[i];

      // Reset and idle
      n_reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, 32'(busy[k]), 0);
         chk("rst_out_data", k, 32'(out_data[k]), 0);
         chk("rst_strobes", k, 32'({in_ready[k], data_ready[k], cnt_up[k], batch_done[k]}), 0);
      end
      n_reset = 1'b1;
      repeat (10) @(negedge clk) chk("idle_busy", 0, 32'(busy[0]), 0);

      // clear beats start in IDLE
      @(posedge clk); #1 clear[0] = 1; start[0] = 1;
      @(posedge clk); #1 clear[0] = 0; start[0] = 0;
      @(negedge clk) chk("clr_start_idle", 0, 32'(busy[0]), 0);

      // Back-to-back 4-sample batch
      b = plog_d[0].size();
      in_valid[0] = 1;
      pulse_start(0);
      wait_bd(0, 100, "b4_done");
      chk("b4_pulses", 0, 32'(plog_d[0].size() - b), 4);
      for (int i = 0; i < 4; i++) chk("b4_data", 0, 32'(plog_d[0][b+i]), 32'(exp4[i]));
      for (int i = 1; i < 4; i++) chk("b4_spacing", 0, 32'(plog_c[0][b+i] - plog_c[0][b+i-1]), 4);
      chk("b4_done_gap", 0, 32'(bd_cyc[0] - plog_c[0][b+3]), 2);
      @(negedge clk) chk("b4_idle", 0, 32'(busy[0]), 0);

      // modwait held high for 7 cycles in ISSUE
      @(posedge clk); #1 modwait[0] = 1;
      pulse_start(0);
      c = 0;
      while (!m_have[0] && c < 50) begin @(negedge clk); c++; end
      chk("stall_reach", 0, 32'(m_have[0]), 1);
      d0 = out_data[0];
      repeat (7) begin
         @(negedge clk);
         chk("stall_no_dr", 0, 32'(data_ready[0]), 0);
         chk("stall_hold", 0, 32'(out_data[0]), 32'(d0));
      end
      @(posedge clk); #1 modwait[0] = 0;
      @(negedge clk) chk("stall_dr_early", 0, 32'(data_ready[0]), 0);
      @(negedge clk) chk("stall_dr_after", 0, 32'(data_ready[0]), 1);
      chk("stall_data", 0, 32'(out_data[0]), 32'(d0));
      wait_bd(0, 100, "stall_done");

      // in_valid low for 5 cycles in FETCH
      in_valid[0] = 0;
      pulse_start(0);
      c = 0;
      while (!m_await[0] && c < 50) begin @(negedge clk); c++; end
      repeat (5) begin
         @(negedge clk);
         chk("starve_ready", 0, 32'(in_ready[0]), 1);
         chk("starve_no_dr", 0, 32'(data_ready[0]), 0);
      end
      @(posedge clk); #1 in_valid[0] = 1; d0 = in_data[0];
      @(negedge clk);
      @(negedge clk);
      @(negedge clk) chk("starve_dr", 0, 32'(data_ready[0]), 1);
      chk("starve_data", 0, 32'(out_data[0]), 32'(d0));
      wait_bd(0, 100, "starve_done");

      // clear after the 2nd sample, then a full batch
      b = plog_d[0].size(); c = bd_cnt[0];
      pulse_start(0);
      begin
         int w = 0;
         while (plog_d[0].size() < b + 2 && w < 100) begin @(posedge clk); w++; end
      end
      #1 clear[0] = 1;
      @(posedge clk); #1 clear[0] = 0;
      @(negedge clk) chk("clr_idle", 0, 32'(busy[0]), 0);
      repeat (20) @(negedge clk);
      chk("clr_pulses", 0, 32'(plog_d[0].size() - b), 2);
      chk("clr_no_done", 0, 32'(bd_cnt[0] - c), 0);
      b = plog_d[0].size();
      pulse_start(0);
      wait_bd(0, 100, "post_clr_done");
      chk("post_clr_pulses", 0, 32'(plog_d[0].size() - b), 4);

      // Default 1000-sample batch with random stalls
      in_valid[1] = 1;
      pulse_start(1);
      for (int i = 0; i < 30000 && bd_cnt[1] == 0; i++) begin
         @(posedge clk); #1;
         modwait[1]  = ($urandom_range(0, 3) == 0);
         in_valid[1] = ($urandom_range(0, 3) != 0);
      end
      chk("k_done", 1, 32'(bd_cnt[1]), 1);
      chk("k_pulses", 1, 32'(plog_c[1].size()), 1000);
      if (plog_c[1].size() > 0)
         chk("k_done_gap", 1, 32'((bd_cyc[1] - plog_c[1][plog_c[1].size()-1]) >= 2), 1);
      modwait[1] = 0; in_valid[1] = 0;
      repeat (3) @(negedge clk);
      chk("k_idle", 1, 32'(busy[1]), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
